// File: rtl/mport_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mport_arbiter
// Description : Round-robin multi-port arbiter routing single-word accesses to
//               an on-chip RAM or an external handshaked memory.
// Revision    : 1.0 - initial release
// ============================================================================
module mport_arbiter #(
    parameter int NUM_PORTS    = 4,
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 24,
    parameter int ONCHIP_WORDS = 8192,
    parameter int TIMEOUT      = 1023
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          p_w_en,
    input  logic [NUM_PORTS-1:0]          p_r_en,
    input  logic [NUM_PORTS*ADDR_W-1:0]   p_addr,
    input  logic [NUM_PORTS*DATA_W-1:0]   p_data_store,
    output logic [DATA_W-1:0]             p_data_read,
    output logic [NUM_PORTS-1:0]          p_done,
    output logic [NUM_PORTS-1:0]          p_err,
    output logic                          oc_w_en,
    output logic [ADDR_W-1:0]             oc_addr,
    output logic [DATA_W-1:0]             oc_data_store,
    input  logic [DATA_W-1:0]             oc_data_load,
    output logic                          mem_w_en,
    output logic                          mem_r_en,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_data_store,
    input  logic                          mem_ready,
    input  logic                          mem_done,
    input  logic [DATA_W-1:0]             mem_data_read
);

    localparam int c_IW = $clog2(NUM_PORTS);
    localparam int c_CW = $clog2(TIMEOUT + 1);

    localparam logic [2:0] c_S_IDLE      = 3'd0;
    localparam logic [2:0] c_S_OC_ACCESS = 3'd1;
    localparam logic [2:0] c_S_MEM_ISSUE = 3'd2;
    localparam logic [2:0] c_S_MEM_WAIT  = 3'd3;
    localparam logic [2:0] c_S_RESPOND   = 3'd4;

    localparam logic [c_IW-1:0] c_LAST_RST = c_IW'(NUM_PORTS - 1);
    localparam logic [c_CW-1:0] c_TMO_LAST = c_CW'(TIMEOUT - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_next;
    logic [c_IW-1:0]   r_last;
    logic [c_IW-1:0]   r_port;
    logic              r_wr;
    logic              r_oc;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [c_CW-1:0]   r_cnt;

    logic [NUM_PORTS-1:0] w_req;
    logic                 w_any;
    logic [c_IW-1:0]      w_pick;
    logic [ADDR_W-1:0]    w_pick_addr;
    logic                 w_pick_oc;
    logic                 w_tmo;

    logic [ADDR_W-1:0] w_addr_arr [NUM_PORTS];
    logic [DATA_W-1:0] w_data_arr [NUM_PORTS];

    generate
        for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
            assign w_addr_arr[g] = p_addr[g*ADDR_W +: ADDR_W];
            assign w_data_arr[g] = p_data_store[g*DATA_W +: DATA_W];
        end
    endgenerate

    // Search begins one past the previous winner so every requester is reached
    // within NUM_PORTS grants.
    function automatic logic [c_IW-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                                 input logic [c_IW-1:0]      last);
        logic [c_IW-1:0] idx;
        logic [c_IW-1:0] pick;
        logic            found;
        idx   = last;
        pick  = last;
        found = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = (idx == c_LAST_RST) ? '0 : idx + c_IW'(1);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign w_req       = p_w_en | p_r_en;
    assign w_any       = |w_req;
    assign w_pick      = rr_pick(w_req, r_last);
    assign w_pick_addr = w_addr_arr[w_pick];
    assign w_pick_oc   = (64'(w_pick_addr) < 64'(ONCHIP_WORDS));
    assign w_tmo       = (r_cnt == c_TMO_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_any) begin
                    w_next = w_pick_oc ? c_S_OC_ACCESS : c_S_MEM_ISSUE;
                end
            end
            c_S_OC_ACCESS: w_next = c_S_RESPOND;
            c_S_MEM_ISSUE: begin
                // mem_done is not looked at here, even alongside mem_ready
                if (w_tmo) begin
                    w_next = c_S_RESPOND;
                end else if (mem_ready) begin
                    w_next = c_S_MEM_WAIT;
                end
            end
            c_S_MEM_WAIT: begin
                if (mem_done || w_tmo) begin
                    w_next = c_S_RESPOND;
                end
            end
            c_S_RESPOND: w_next = c_S_IDLE;
            default:     w_next = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last  <= c_LAST_RST;
            r_port  <= '0;
            r_wr    <= 1'b0;
            r_oc    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    r_cnt   <= '0;
                    r_err   <= 1'b0;
                    r_rdata <= '0;
                    if (w_any) begin
                        r_port  <= w_pick;
                        r_wr    <= p_w_en[w_pick];
                        r_oc    <= w_pick_oc;
                        r_addr  <= w_pick_addr;
                        r_wdata <= w_data_arr[w_pick];
                    end
                end
                c_S_MEM_ISSUE, c_S_MEM_WAIT: begin
                    r_cnt <= r_cnt + c_CW'(1);
                    // A real completion beats a timeout landing on the same cycle
                    if ((r_state == c_S_MEM_WAIT) && mem_done) begin
                        r_rdata <= mem_data_read;
                    end else if (w_tmo) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end
                end
                c_S_RESPOND: r_last <= r_port;
                default: ;
            endcase
        end
    end

    always_comb begin
        p_done         = '0;
        p_err          = '0;
        p_data_read    = '0;
        oc_w_en        = 1'b0;
        oc_addr        = '0;
        oc_data_store  = '0;
        mem_w_en       = 1'b0;
        mem_r_en       = 1'b0;
        mem_addr       = '0;
        mem_data_store = '0;
        case (r_state)
            c_S_OC_ACCESS: begin
                oc_w_en       = r_wr;
                oc_addr       = r_addr;
                oc_data_store = r_wdata;
            end
            c_S_MEM_ISSUE: begin
                mem_w_en       = r_wr;
                mem_r_en       = !r_wr;
                mem_addr       = r_addr;
                mem_data_store = r_wdata;
            end
            c_S_RESPOND: begin
                p_done[r_port] = 1'b1;
                p_err[r_port]  = r_err;
                // The on-chip RAM output is valid exactly in this cycle
                if (!r_wr && !r_err) begin
                    p_data_read = r_oc ? oc_data_load : r_rdata;
                end
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mport_arbiter.sv
`default_nettype none
// Testbench for mport_arbiter: scoreboard of expected completions checked
// against every p_done pulse, plus directed timing and routing checks.
module tb_mport_arbiter;

    localparam int NP  = 4;
    localparam int DW  = 32;
    localparam int AW  = 24;
    localparam int OCW = 8192;
    localparam int TMO = 15;

    logic              clk;
    logic              rst;
    logic [NP-1:0]     p_w_en;
    logic [NP-1:0]     p_r_en;
    logic [NP*AW-1:0]  p_addr;
    logic [NP*DW-1:0]  p_data_store;
    logic [DW-1:0]     p_data_read;
    logic [NP-1:0]     p_done;
    logic [NP-1:0]     p_err;
    logic              oc_w_en;
    logic [AW-1:0]     oc_addr;
    logic [DW-1:0]     oc_data_store;
    logic [DW-1:0]     oc_data_load;
    logic              mem_w_en;
    logic              mem_r_en;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_data_store;
    logic              mem_ready;
    logic              mem_done;
    logic [DW-1:0]     mem_data_read;

    logic [DW-1:0] ocram [0:OCW-1];

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;
    int done_cyc = 0;
    int cyc      = 0;

    typedef struct {
        int            port;
        logic [DW-1:0] data;
        logic          err;
    } exp_t;

    exp_t exp_q[$];

    mport_arbiter #(
        .NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW),
        .ONCHIP_WORDS(OCW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .p_w_en(p_w_en), .p_r_en(p_r_en), .p_addr(p_addr), .p_data_store(p_data_store),
        .p_data_read(p_data_read), .p_done(p_done), .p_err(p_err),
        .oc_w_en(oc_w_en), .oc_addr(oc_addr), .oc_data_store(oc_data_store),
        .oc_data_load(oc_data_load),
        .mem_w_en(mem_w_en), .mem_r_en(mem_r_en), .mem_addr(mem_addr),
        .mem_data_store(mem_data_store), .mem_ready(mem_ready), .mem_done(mem_done),
        .mem_data_read(mem_data_read)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // On-chip RAM: one-cycle read latency, read-before-write
    always @(posedge clk) begin
        oc_data_load <= ocram[oc_addr[12:0]];
        if (oc_w_en) ocram[oc_addr[12:0]] = oc_data_store;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (p_done != '0) begin
            n_done++;
            done_cyc = cyc;
            if (exp_q.size() == 0) begin
                check_eq("unexpected_done", 64'(p_done), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("done_port", 64'(p_done), 64'(1) << e.port);
                check_eq("done_err", 64'(p_err), e.err ? (64'(1) << e.port) : 64'd0);
                check_eq("rdata", 64'(p_data_read), 64'(e.data));
            end
        end else if (p_err != '0) begin
            check_eq("err_without_done", 64'(p_err), 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic w, input logic r,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        p_w_en[p] = w;
        p_r_en[p] = r;
        p_addr[p*AW +: AW] = a;
        p_data_store[p*DW +: DW] = d;
    endtask

    task automatic expect_done(input int p, input logic [DW-1:0] d, input logic e);
        exp_t x;
        x.port = p;
        x.data = d;
        x.err  = e;
        exp_q.push_back(x);
    endtask

    task automatic wait_done(input int target, input int budget);
        int k;
        k = 0;
        while (n_done < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (n_done < target) check_eq("wait_done", 64'(n_done), 64'(target));
    endtask

    int t0;

    initial begin
        rst = 1'b1;
        p_w_en = '0;
        p_r_en = '0;
        p_addr = '0;
        p_data_store = '0;
        mem_ready = 1'b0;
        mem_done = 1'b0;
        mem_data_read = '0;
        for (int i = 0; i < OCW; i++) ocram[i] = '0;
        for (int i = 0; i < NP; i++) ocram[16'h100 + i] = 32'hA000_0100 + i;
        ocram[16'h20] = 32'hA000_0020;
        ocram[16'h30] = 32'hA000_0030;
        ocram[16'h31] = 32'hA000_0031;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_p_done", 64'(p_done), 64'd0);
        check_eq("rst_p_err", 64'(p_err), 64'd0);
        check_eq("rst_p_data_read", 64'(p_data_read), 64'd0);
        check_eq("rst_oc_w_en", 64'(oc_w_en), 64'd0);
        check_eq("rst_oc_addr", 64'(oc_addr), 64'd0);
        check_eq("rst_mem_en", 64'({mem_w_en, mem_r_en}), 64'd0);
        check_eq("rst_mem_addr", 64'(mem_addr), 64'd0);

        // Fairness: all four ports request continuously from reset release
        for (int i = 0; i < NP; i++) set_port(i, 1'b0, 1'b1, AW'(24'h100 + i), '0);
        for (int i = 0; i < NP; i++) expect_done(i, 32'hA000_0100 + i, 1'b0);
        expect_done(0, 32'hA000_0100, 1'b0);
        tick();
        check_eq("rst_held_no_done", 64'(p_done), 64'd0);
        rst = 1'b0;
        t0 = cyc;
        wait_done(1, 10);
        check_eq("first_grant_latency", 64'(done_cyc), 64'(t0 + 2));
        wait_done(5, 40);
        p_r_en = '0;

        // On-chip write then read from port 1
        tick();
        expect_done(1, 32'h0, 1'b0);
        set_port(1, 1'b1, 1'b0, 24'h10, 32'hDEAD_BEEF);
        t0 = cyc;
        tick();
        check_eq("oc_wr_en", 64'(oc_w_en), 64'd1);
        check_eq("oc_wr_addr", 64'(oc_addr), 64'h10);
        check_eq("oc_wr_data", 64'(oc_data_store), 64'hDEAD_BEEF);
        check_eq("oc_wr_no_mem", 64'({mem_w_en, mem_r_en}), 64'd0);
        set_port(1, 1'b0, 1'b0, '0, '0);
        wait_done(6, 10);
        check_eq("oc_wr_latency", 64'(done_cyc), 64'(t0 + 2));
        tick();
        expect_done(1, 32'hDEAD_BEEF, 1'b0);
        set_port(1, 1'b0, 1'b1, 24'h10, '0);
        t0 = cyc;
        tick();
        check_eq("oc_rd_w_en", 64'(oc_w_en), 64'd0);
        check_eq("oc_rd_addr", 64'(oc_addr), 64'h10);
        set_port(1, 1'b0, 1'b0, '0, '0);
        wait_done(7, 10);
        check_eq("oc_rd_latency", 64'(done_cyc), 64'(t0 + 2));

        // External read, ready after 3 stalled cycles, done 5 cycles later
        tick();
        expect_done(2, 32'h1234_5678, 1'b0);
        set_port(2, 1'b0, 1'b1, 24'h2000, '0);
        tick();
        set_port(2, 1'b0, 1'b0, '0, '0);
        for (int k = 0; k < 3; k++) begin
            check_eq("mem_issue_r_en", 64'({mem_w_en, mem_r_en}), 64'd1);
            check_eq("mem_issue_addr", 64'(mem_addr), 64'h2000);
            tick();
        end
        check_eq("mem_issue_addr_last", 64'(mem_addr), 64'h2000);
        mem_ready = 1'b1;
        mem_done = 1'b1;
        mem_data_read = 32'hBAD0_BAD0;
        tick();
        mem_ready = 1'b0;
        mem_done = 1'b0;
        mem_data_read = '0;
        check_eq("mem_wait_en_low", 64'({mem_w_en, mem_r_en}), 64'd0);
        check_eq("mem_wait_no_done", 64'(p_done), 64'd0);
        repeat (4) tick();
        mem_done = 1'b1;
        mem_data_read = 32'h1234_5678;
        t0 = cyc;
        tick();
        mem_done = 1'b0;
        mem_data_read = '0;
        wait_done(8, 10);
        check_eq("mem_done_latency", 64'(done_cyc), 64'(t0 + 1));

        // Timeout on port 3 while port 0 waits for an on-chip read
        tick();
        expect_done(3, 32'h0, 1'b1);
        expect_done(0, 32'hA000_0020, 1'b0);
        set_port(3, 1'b0, 1'b1, 24'h3000, '0);
        set_port(0, 1'b0, 1'b1, 24'h20, '0);
        tick();
        t0 = cyc;
        set_port(3, 1'b0, 1'b0, '0, '0);
        repeat (2) tick();
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        wait_done(9, 30);
        check_eq("timeout_latency", 64'(done_cyc), 64'(t0 + TMO));
        t0 = done_cyc;
        wait_done(10, 10);
        check_eq("after_timeout_next", 64'(done_cyc), 64'(t0 + 3));
        set_port(0, 1'b0, 1'b0, '0, '0);

        // Reset during MEM_WAIT drops the access; port 0 then wins over port 3
        tick();
        set_port(1, 1'b0, 1'b1, 24'h4000, '0);
        tick();
        set_port(1, 1'b0, 1'b0, '0, '0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
        set_port(0, 1'b0, 1'b1, 24'h30, '0);
        set_port(3, 1'b0, 1'b1, 24'h31, '0);
        #2 rst = 1'b1;
        mem_done = 1'b1;
        mem_data_read = 32'hFFFF_FFFF;
        #1;
        check_eq("rst_async_done", 64'(p_done), 64'd0);
        check_eq("rst_async_mem", 64'({mem_w_en, mem_r_en, mem_addr}), 64'd0);
        check_eq("rst_async_rdata", 64'(p_data_read), 64'd0);
        repeat (2) tick();
        mem_done = 1'b0;
        mem_data_read = '0;
        expect_done(0, 32'hA000_0030, 1'b0);
        expect_done(3, 32'hA000_0031, 1'b0);
        rst = 1'b0;
        t0 = cyc;
        wait_done(11, 10);
        check_eq("post_rst_latency", 64'(done_cyc), 64'(t0 + 2));
        wait_done(12, 10);
        p_r_en = '0;

        // Boundary routing; both enables set means write
        tick();
        expect_done(2, 32'h0, 1'b0);
        set_port(2, 1'b1, 1'b1, AW'(OCW - 1), 32'hCAFE_F00D);
        tick();
        check_eq("bnd_oc_w_en", 64'(oc_w_en), 64'd1);
        check_eq("bnd_oc_addr", 64'(oc_addr), 64'(OCW - 1));
        check_eq("bnd_oc_no_mem", 64'({mem_w_en, mem_r_en}), 64'd0);
        set_port(2, 1'b0, 1'b0, '0, '0);
        wait_done(13, 10);
        tick();
        expect_done(2, 32'hCAFE_F00D, 1'b0);
        set_port(2, 1'b0, 1'b1, AW'(OCW - 1), '0);
        tick();
        set_port(2, 1'b0, 1'b0, '0, '0);
        wait_done(14, 10);
        tick();
        expect_done(1, 32'h0, 1'b0);
        set_port(1, 1'b1, 1'b1, AW'(OCW), 32'h0BAD_F00D);
        tick();
        check_eq("bnd_mem_en", 64'({mem_w_en, mem_r_en}), 64'd2);
        check_eq("bnd_mem_addr", 64'(mem_addr), 64'(OCW));
        check_eq("bnd_mem_data", 64'(mem_data_store), 64'h0BAD_F00D);
        check_eq("bnd_mem_no_oc", 64'(oc_w_en), 64'd0);
        set_port(1, 1'b0, 1'b0, '0, '0);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        mem_done = 1'b1;
        mem_data_read = 32'h7777_7777;
        tick();
        mem_done = 1'b0;
        mem_data_read = '0;
        wait_done(15, 10);

        // Reset asserted mid-cycle in MEM_ISSUE clears the request immediately
        tick();
        set_port(2, 1'b1, 1'b0, 24'h5000, 32'h5555_5555);
        tick();
        set_port(2, 1'b0, 1'b0, '0, '0);
        check_eq("issue_w_en", 64'(mem_w_en), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("rst_async_issue", 64'({mem_w_en, mem_r_en, mem_addr}), 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        repeat (4) tick();

        check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        check_eq("done_total", 64'(n_done), 64'd15);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
